// File: rtl/chiplib_riscv_plic_gateway.sv
// chiplib_riscv_plic_gateway
// One interrupt gateway per PLIC source (1..NumSources-1; source 0 is reserved).
// Raw lines are synchronised, then each source runs a small IDLE/PEND/CLAIMED
// machine. Edge sources remember events that arrive while busy.
// Optional feature macro: CHIPLIB_RISCV_PLIC_GATEWAY_EDGE_COUNT_EN
//   defined   -> edge events are counted up to MaxEdgeCount
//   undefined -> each edge source latches a single pending event bit
module chiplib_riscv_plic_gateway #(
    parameter int                    NumSources   = 100,
    parameter int                    SyncStages   = 2,
    parameter logic [NumSources-1:0] EdgeMask     = '0,
    parameter int                    MaxEdgeCount = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NumSources-1:0] irq_src,
    input  logic [NumSources-1:0] irq_claim,
    input  logic [NumSources-1:0] irq_complete,
    output logic [NumSources-1:0] irq_pend,
    output logic [NumSources-1:0] irq_active,
    output logic [NumSources-1:0] irq_overflow
);

`ifdef CHIPLIB_RISCV_PLIC_GATEWAY_EDGE_COUNT_EN
    localparam int CntMax = MaxEdgeCount;
`else
    // A single latched event behaves like a counter that saturates at 1.
    localparam int CntMax = (MaxEdgeCount >= 1) ? 1 : 1;
`endif
    localparam int              CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] CntTop = CntW'(CntMax);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        CLAIMED = 2'd2
    } state_t;

    logic [NumSources-1:0] req;
    // High once req carries genuinely sampled values rather than reset zeros.
    logic                  sync_filled;

    generate
        if (SyncStages == 0) begin : g_nosync
            assign req         = irq_src;
            assign sync_filled = 1'b1;
        end else begin : g_sync
            logic [NumSources-1:0] sync_q [SyncStages];
            logic [SyncStages-1:0] fill_q;

            // Shift raw lines through the synchroniser alongside a fill marker.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
                    fill_q <= '0;
                end else begin
                    sync_q[0] <= irq_src;
                    fill_q[0] <= 1'b1;
                    for (int k = 1; k < SyncStages; k++) begin
                        sync_q[k] <= sync_q[k-1];
                        fill_q[k] <= fill_q[k-1];
                    end
                end
            end

            assign req         = sync_q[SyncStages-1];
            assign sync_filled = fill_q[SyncStages-1];
        end
    endgenerate

    // Source 0 is reserved: outputs tied low, inputs deliberately dropped.
    assign irq_pend[0]     = 1'b0;
    assign irq_active[0]   = 1'b0;
    assign irq_overflow[0] = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{irq_claim[0], irq_complete[0], req[0], sync_filled};

    generate
        for (genvar i = 1; i < NumSources; i++) begin : g_src
            if (EdgeMask[i]) begin : g_edge
                state_t          state;
                logic            prev;
                logic            armed;
                logic            ovf;
                logic [CntW-1:0] cnt;
                logic            ev;

                // A rising edge only counts once a real 0 has been sampled, so a
                // line held high through reset release is not taken as an edge.
                assign ev = armed & req[i] & ~prev;

                // Edge gateway: state machine plus saturating event store.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        state <= IDLE;
                        cnt   <= '0;
                        prev  <= 1'b0;
                        armed <= 1'b0;
                        ovf   <= 1'b0;
                    end else begin
                        prev  <= req[i];
                        armed <= armed | (sync_filled & ~req[i]);
                        ovf   <= 1'b0;
                        case (state)
                            IDLE: begin
                                // A fresh edge is consumed directly; otherwise
                                // take one stored event. Both together leave cnt.
                                if (ev || (cnt != '0)) begin
                                    state <= PEND;
                                    if (!ev) cnt <= cnt - CntW'(1);
                                end
                            end
                            PEND:    if (irq_claim[i])    state <= CLAIMED;
                            CLAIMED: if (irq_complete[i]) state <= IDLE;
                            default: state <= IDLE;
                        endcase
                        if (ev && (state != IDLE)) begin
                            if (cnt == CntTop) ovf <= 1'b1;
                            else               cnt <= cnt + CntW'(1);
                        end
                    end
                end

                assign irq_pend[i]     = (state == PEND);
                assign irq_active[i]   = (state == CLAIMED);
                assign irq_overflow[i] = ovf;
            end else begin : g_level
                state_t state;

                // Level gateway: request re-pends whenever the line is high in IDLE.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        state <= IDLE;
                    end else begin
                        case (state)
                            IDLE:    if (req[i])          state <= PEND;
                            PEND:    if (irq_claim[i])    state <= CLAIMED;
                            CLAIMED: if (irq_complete[i]) state <= IDLE;
                            default: state <= IDLE;
                        endcase
                    end
                end

                assign irq_pend[i]     = (state == PEND);
                assign irq_active[i]   = (state == CLAIMED);
                assign irq_overflow[i] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: doc/chiplib_riscv_plic_gateway.md
CHIPLIB_RISCV_PLIC_GATEWAY -- requirements
Module: chiplib_riscv_plic_gateway

Interface
REQ-001 SHALL have parameter NumSources, default 100, source count including reserved source 0.
REQ-002 SHALL have parameter SyncStages, default 2, flip-flop synchroniser depth per source (0 = no synchroniser).
REQ-003 SHALL have parameter EdgeMask [NumSources-1:0], default all 0, bit=1 selects edge-triggered, 0 selects level-triggered.
REQ-004 SHALL have parameter MaxEdgeCount, default 7, saturation value of the per-source edge counter (>=1).
REQ-005 SHALL have port clk  input  1  sole clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port irq_src  input  NumSources  raw interrupt lines, asynchronous to clk.
REQ-008 SHALL have port irq_claim  input  NumSources  one-cycle claim strobes, one-hot or zero.
REQ-009 SHALL have port irq_complete  input  NumSources  one-cycle completion strobes.
REQ-010 SHALL have port irq_pend  output  NumSources  pending bits to the PLIC core.
REQ-011 SHALL have port irq_active  output  NumSources  source claimed and in service.
REQ-012 SHALL have port irq_overflow  output  NumSources  one-cycle pulse when an edge is dropped at saturation.

Function
REQ-013 SHALL run one independent gateway per source 1..NumSources-1; bit 0 of every output SHALL be constant 0 and bit 0 of every input ignored.
REQ-014 SHALL synchronise irq_src[i] through SyncStages flops; "req" below denotes the synchronised value.
REQ-015 SHALL implement per-source states IDLE, PEND, CLAIMED; irq_pend=1 only in PEND, irq_active=1 only in CLAIMED.
REQ-016 Level source: IDLE with req=1 SHALL go to PEND next cycle; src high at cycle t gives irq_pend=1 at t+SyncStages+1.
REQ-017 Level source in PEND SHALL stay pending if req deasserts before claim.
REQ-018 Edge source: a 0->1 transition of req SHALL be an edge event; IDLE with an edge event or edge count>0 SHALL go to PEND, consuming one event.
REQ-019 PEND with irq_claim[i]=1 SHALL go to CLAIMED next cycle; a claim in IDLE or CLAIMED SHALL be ignored.
REQ-020 CLAIMED with irq_complete[i]=1 SHALL go to IDLE next cycle; a complete in IDLE or PEND SHALL be ignored.
REQ-021 Claim and complete of the same source in the same cycle SHALL act per current state only (at most one applies).
REQ-022 Edge events arriving in PEND or CLAIMED SHALL increment the counter, saturating at MaxEdgeCount; an event at saturation SHALL pulse irq_overflow[i] for one cycle.
REQ-023 Simultaneous edge event and count consumption SHALL leave the count unchanged.
REQ-024 Counter width SHALL be $clog2(MaxEdgeCount+1); no wrap-around permitted.

Reset
REQ-025 rst assertion SHALL asynchronously force all sources to IDLE, edge counters and synchroniser/edge-detect flops to 0.
REQ-026 During and after reset, irq_pend, irq_active, irq_overflow SHALL be 0; a source high through reset release SHALL be seen as a level request, and as an edge only after a 0 is sampled.
REQ-027 Reset mid-service SHALL discard claims in flight; later completes SHALL be ignored per REQ-020.

Configuration
REQ-028 With macro CHIPLIB_RISCV_PLIC_GATEWAY_EDGE_COUNT_EN defined, edge counters SHALL behave per REQ-022..024.
REQ-029 Without it, each edge source SHALL hold a single latched event bit; extra edges while latched, PEND or CLAIMED SHALL pulse irq_overflow and be dropped.

Verification
REQ-030 Level: SyncStages=2, irq_src[5] high at cycle 10 -> irq_pend[5]=1 at cycle 13; claim at 20 -> irq_active[5]=1 at 21; complete at 30 with src still high -> irq_pend[5]=1 at 32.
REQ-031 Edge counting: 3 pulses on irq_src[7] before claim -> after each claim/complete pair, pend re-asserts; exactly 3 services, then idle.
REQ-032 Saturation: MaxEdgeCount=7, 9 edges during CLAIMED -> count=7, irq_overflow[7] pulses exactly twice.
REQ-033 Illegal strobes: claim to IDLE source 3 and complete to PEND source 4 -> no state change on either.
REQ-034 Reset: rst asserted while source 9 CLAIMED with count=2 -> all outputs 0 immediately, count 0, complete after release ignored.
REQ-035 Macro undefined: 2 edges on source 7 during CLAIMED -> one service after complete, irq_overflow[7] pulses once.
